// File: rtl/cprv_ram_pkg.sv
// ============================================================================
//  Module      : cprv_ram_pkg
//  Description : Shared types, constants and byte-merge helper for cprv_ram_2p.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cprv_ram_pkg;

    typedef enum logic [0:0] {
        RAM_INIT  = 1'b0,
        RAM_READY = 1'b1
    } ram_state_e;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // Widest word byte_merge handles; callers zero-extend into this width.
    localparam int c_MERGE_MAX_W  = 1024;
    localparam int c_MERGE_MAX_BE = c_MERGE_MAX_W / 8;

    function automatic logic [c_MERGE_MAX_W-1:0] byte_merge(
        input logic [c_MERGE_MAX_W-1:0]  old_word,
        input logic [c_MERGE_MAX_W-1:0]  new_word,
        input logic [c_MERGE_MAX_BE-1:0] be
    );
        logic [c_MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < c_MERGE_MAX_BE; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cprv_ram_out_stage.sv
// ============================================================================
//  Module      : cprv_ram_out_stage
//  Description : Optional read-data/valid output register; data held between reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cprv_ram_out_stage #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);
    import cprv_ram_pkg::*;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = in_valid;
        data_d  = in_valid ? in_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/cprv_ram_2p.sv
// ============================================================================
//  Module      : cprv_ram_2p
//  Description : 1W/1R synchronous RAM with byte enables, RDW policy, optional
//                output register and post-reset hardware clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cprv_ram_2p #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 64,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done,
    input  logic                    w_en,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH/8-1:0] w_be,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    r_en,
    input  logic [ADDR_WIDTH-1:0]   r_addr,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    r_valid
);
    import cprv_ram_pkg::*;

    localparam int c_DEPTH = 2**ADDR_WIDTH;

    if (((DATA_WIDTH % 8) != 0) || (DATA_WIDTH > c_MERGE_MAX_W)) begin : g_bad_width
        $error("cprv_ram_2p: DATA_WIDTH must be a multiple of 8 and at most %0d", c_MERGE_MAX_W);
    end

    ram_state_e             state_q,    state_d;
    logic [ADDR_WIDTH-1:0]  clr_cnt_q,  clr_cnt_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]  rd_data_q,  rd_data_d;
    logic [DATA_WIDTH-1:0]  mem_q [c_DEPTH];

    logic                   w_ready;
    logic                   w_wr_fire;
    logic                   w_rd_fire;
    logic                   w_clr_fire;
    logic                   w_collide;
    logic [DATA_WIDTH-1:0]  w_wr_merged;
    logic [DATA_WIDTH-1:0]  w_rd_word;
    logic                   w_mem_we;
    logic [ADDR_WIDTH-1:0]  w_mem_addr;
    logic [DATA_WIDTH-1:0]  w_mem_wdata;

    assign w_ready    = (state_q == RAM_READY);
    assign w_wr_fire  = rst_n && w_ready && w_en;
    assign w_rd_fire  = rst_n && w_ready && r_en;
    assign w_clr_fire = rst_n && (CLEAR_ON_RESET != 0) && (state_q == RAM_INIT);
    assign w_collide  = w_wr_fire && w_rd_fire && (w_addr == r_addr);

    // Read-modify-write merge; also serves as the write-first bypass value.
    assign w_wr_merged = DATA_WIDTH'(byte_merge(c_MERGE_MAX_W'(mem_q[w_addr]),
                                                c_MERGE_MAX_W'(w_data),
                                                c_MERGE_MAX_BE'(w_be)));

    assign w_rd_word = (w_collide && (RDW_MODE == RDW_WRITE_FIRST)) ? w_wr_merged
                                                                    : mem_q[r_addr];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == RAM_INIT) begin
            if (CLEAR_ON_RESET != 0) begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (&clr_cnt_q) begin
                    state_d = RAM_READY;
                end
            end else begin
                state_d = RAM_READY;
            end
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = w_addr;
        w_mem_wdata = w_wr_merged;
        if (w_clr_fire) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = clr_cnt_q;
            w_mem_wdata = '0;
        end else if (w_wr_fire) begin
            w_mem_we    = 1'b1;
        end
    end

    always_comb begin
        rd_valid_d = w_rd_fire;
        rd_data_d  = w_rd_fire ? w_rd_word : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RAM_INIT;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        cprv_ram_out_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_out_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (rd_valid_q),
            .in_data   (rd_data_q),
            .out_valid (r_valid),
            .out_data  (r_data)
        );
    end else begin : g_no_out_reg
        assign r_valid = rd_valid_q;
        assign r_data  = rd_data_q;
    end

    assign init_done = w_ready;

endmodule

`default_nettype wire

// File: tb/tb_cprv_ram_2p.sv
// ============================================================================
//  Module      : tb_cprv_ram_2p
//  Description : Self-checking bench for cprv_ram_2p (two configurations, shared stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cprv_ram_2p;

    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int BEW   = DW / 8;
    localparam int DEPTH = 2**AW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           w_en, r_en;
    logic [AW-1:0]  w_addr, r_addr;
    logic [BEW-1:0] w_be;
    logic [DW-1:0]  w_data;

    logic           done0, done1, rv0, rv1;
    logic [DW-1:0]  rd0, rd1;

    always #5 clk = ~clk;

    // Instance 0: latency 1, write-first. Instance 1: latency 2, read-first.
    cprv_ram_2p #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .init_done(done0),
        .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd0), .r_valid(rv0)
    );

    cprv_ram_2p #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_done(done1),
        .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd1), .r_valid(rv1)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_item_t;

    rd_item_t      q0[$];
    rd_item_t      q1[$];
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_d0 = '0;
    logic [DW-1:0] exp_d1 = '0;
    int            rel_edges = 0;
    int            edge_n    = 0;
    int            checks    = 0;
    int            failures  = 0;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                  input logic [DW-1:0] new_w,
                                                  input logic [BEW-1:0] be);
        logic [DW-1:0] res;
        for (int i = 0; i < BEW; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [BEW-1:0] be,
                         input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        w_en   = we;
        w_addr = wa;
        w_be   = be;
        w_data = wd;
        r_en   = re;
        r_addr = ra;
    endtask

    // One clock: update the reference with the inputs seen at the edge, then compare.
    task automatic step();
        logic          ready;
        logic          ev0, ev1;
        logic [DW-1:0] old_w, v0;
        ready = (rel_edges >= DEPTH);
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            exp_d0    = '0;
            exp_d1    = '0;
            rel_edges = 0;
        end else begin
            if (ready && r_en) begin
                old_w = mem_m[r_addr];
                v0    = (w_en && (w_addr == r_addr)) ? merge_bytes(old_w, w_data, w_be) : old_w;
                q0.push_back('{due: edge_n,     data: v0});
                q1.push_back('{due: edge_n + 1, data: old_w});
            end
            if (ready && w_en) begin
                mem_m[w_addr] = merge_bytes(mem_m[w_addr], w_data, w_be);
            end
            if (rel_edges < DEPTH) begin
                rel_edges++;
                if (rel_edges == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
                end
            end
        end
        @(posedge clk);
        #1;
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (q0.size() > 0 && q0[0].due == edge_n) begin
            ev0    = 1'b1;
            exp_d0 = q0[0].data;
            void'(q0.pop_front());
        end
        if (q1.size() > 0 && q1[0].due == edge_n) begin
            ev1    = 1'b1;
            exp_d1 = q1[0].data;
            void'(q1.pop_front());
        end
        chk("init_done0", DW'(done0), DW'(rel_edges >= DEPTH));
        chk("init_done1", DW'(done1), DW'(rel_edges >= DEPTH));
        chk("r_valid0",   DW'(rv0),   DW'(ev0));
        chk("r_valid1",   DW'(rv1),   DW'(ev1));
        chk("r_data0",    rd0,        exp_d0);
        chk("r_data1",    rd1,        exp_d1);
        edge_n++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        // Reset state.
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        step();
        step();

        // Clear sequence with accesses attempted while not ready.
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, AW'(2), '1, '1, 1'b1, AW'(2));
            step();
        end

        // Every word reads back as zero after the clear.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        step();
        step();

        // Byte enables.
        drive(1'b1, AW'(3), 8'hFF, 64'h1122334455667788, 1'b0, '0);
        step();
        drive(1'b1, AW'(3), 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, '0);
        step();
        drive(1'b1, AW'(4), 8'h00, 64'hDEADBEEFDEADBEEF, 1'b1, AW'(3));
        step();
        drive(1'b0, '0, '0, '0, 1'b1, AW'(4));
        step();
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        step();
        step();

        // Same-address collision on a zero word.
        drive(1'b1, AW'(5), 8'h01, '1, 1'b1, AW'(5));
        step();
        drive(1'b0, '0, '0, '0, 1'b1, AW'(5));
        step();
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        step();
        step();

        // Back-to-back reads of distinct words.
        drive(1'b1, AW'(1), '1, 64'h0101010101010101, 1'b0, '0);
        step();
        drive(1'b1, AW'(2), '1, 64'h0202020202020202, 1'b0, '0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        step();
        step();

        // Randomized traffic with a bias toward same-address collisions.
        for (int n = 0; n < 300; n++) begin
            w_en   = ($urandom_range(0, 1) == 1);
            r_en   = ($urandom_range(0, 1) == 1);
            w_addr = AW'($urandom_range(0, DEPTH - 1));
            r_addr = ($urandom_range(0, 3) == 0) ? w_addr : AW'($urandom_range(0, DEPTH - 1));
            w_be   = ($urandom_range(0, 7) == 0) ? '0 : BEW'($urandom());
            w_data = {$urandom(), $urandom()};
            step();
        end

        // Reset while a read is in flight, then the clear must restart.
        drive(1'b0, '0, '0, '0, 1'b1, AW'(7));
        step();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
            step();
        end
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
